flow_table_match: RTL and testbench
===================================

FLOW_TABLE_MATCH -- requirements
Module: flow_table_match

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: number of flow table entries (power of two, 2..64).
REQ-002 SHALL have parameter ACTION_W, default 8: width of the action field.
REQ-003 SHALL have parameter MISS_ACTION, default 0: action reported on a lookup miss.
REQ-004 SHALL have port clk  in  1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port key_valid  in  1: flow_key is valid this cycle.
REQ-007 SHALL have port key_ready  out  1: block accepts flow_key this cycle.
REQ-008 SHALL have port flow_key  in  96: lookup key from flow_key_gen, {src_ip, dst_ip, src_port, dst_port}.
REQ-009 SHALL have port res_valid  out  1: lookup result valid.
REQ-010 SHALL have port res_ready  in  1: downstream accepts the result.
REQ-011 SHALL have port res_hit  out  1: key matched a valid entry.
REQ-012 SHALL have port res_index  out  log2(ENTRIES): matched entry index; 0 on a miss.
REQ-013 SHALL have port res_action  out  ACTION_W: action of the matched entry, or MISS_ACTION on a miss.
REQ-014 SHALL have port cfg_wr_en  in  1: table write strobe (PS side).
REQ-015 SHALL have port cfg_addr  in  log2(ENTRIES): entry to write, or hit counter to read.
REQ-016 SHALL have ports cfg_key  in  96, cfg_action  in  ACTION_W, cfg_entry_valid  in  1: entry contents to write.
REQ-017 SHALL have ports stat_rd_en  in  1, stat_rd_data  out  32: hit counter read.

Function
REQ-018 SHALL contain ENTRIES entries, each holding a valid bit, a 96-bit key, an action and a 32-bit hit counter.
REQ-019 SHALL accept a key when key_valid and key_ready are both 1.
REQ-020 SHALL use a 2-stage pipeline: S1 registers the per-entry match vector (valid and key equal); S2 priority-encodes it into the result register.
REQ-021 SHALL assert res_valid exactly 2 cycles after acceptance when no stall occurs.
REQ-022 SHALL advance both stages together on adv = !res_valid || res_ready; key_ready SHALL equal adv.
REQ-023 SHALL hold res_valid, res_hit, res_index and res_action stable while res_valid && !res_ready.
REQ-024 SHALL create a bubble in the pipeline when adv=1 and no key is accepted.
REQ-025 SHALL select the lowest matching index when more than one entry matches.
REQ-026 SHALL write the entry at cfg_addr on cfg_wr_en; the write SHALL take effect the following cycle.
REQ-027 SHALL make S1 compare against pre-write contents when a write and an S1 capture occur in the same cycle.
REQ-028 SHALL clear the written entry's hit counter to 0 on any write to it.
REQ-029 SHALL increment the hit counter of res_index on a hit transfer (res_valid && res_ready && res_hit), saturating at 0xFFFFFFFF.
REQ-030 SHALL give priority to the clear when a write and an increment target the same entry in the same cycle.
REQ-031 SHALL put the hit counter at cfg_addr on stat_rd_data one cycle after stat_rd_en; stat_rd_data SHALL otherwise hold its last value.
REQ-032 SHALL report a miss with res_hit=0, res_index=0 and res_action=MISS_ACTION.

Reset
REQ-033 SHALL, on rst, clear all entry valid bits, keys, actions and hit counters, and drop S1/S2 contents.
REQ-034 SHALL drive res_valid=0, res_hit=0, res_index=0, res_action=MISS_ACTION and stat_rd_data=0 during reset and in the first cycle after it; key_ready SHALL be 1 after reset.
REQ-035 SHALL discard in-flight lookups when rst is asserted mid-operation and produce no result for them.

Verification
REQ-036 SHALL be verified by writing entry 3 = {key K1, action 0x5A, valid}, sending K1 with res_ready=1 -> 2 cycles later res_valid=1, res_hit=1, res_index=3, res_action=0x5A; a stat read of entry 3 returns 1.
REQ-037 SHALL be verified by sending an unmatched key -> res_hit=0, res_index=0, res_action=MISS_ACTION; no hit counter changes.
REQ-038 SHALL be verified by writing K1 into entries 2 and 7 and looking up K1 -> res_index=2.
REQ-039 SHALL be verified by sending back-to-back keys with res_ready=0 for 3 cycles -> key_ready=0 while the result is stalled, the result is held stable, there is no loss or duplication, and order is preserved after release.
REQ-040 SHALL be verified by rewriting entry 3 in the same cycle as a hit transfer on entry 3 -> counter reads 0; a lookup accepted in that cycle uses the old contents.
REQ-041 SHALL be verified by asserting rst with 2 lookups in flight -> no res_valid afterwards; all entries miss.

Source files
------------

// File: rtl/flow_table_match.sv
// -----------------------------------------------------------------------------
// flow_table_match
//
// Exact-match flow table. Each entry holds a valid bit, a 96-bit flow key,
// an action and a saturating 32-bit hit counter. Lookups pass through a
// 2-stage pipeline. S1 registers the per-entry match vector, together with a
// snapshot of the actions. S2 priority-encodes the vector into the result
// register, and the lowest matching index wins. Both stages move together
// whenever the result register is empty or being drained.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   key_valid/ready  : lookup key handshake; key_ready == pipeline advance
//   flow_key  [95:0] : {src_ip, dst_ip, src_port, dst_port}
//   res_valid/ready  : result handshake
//   res_hit          : key matched a valid entry
//   res_index        : matched entry index (0 on miss)
//   res_action       : matched entry action (MISS_ACTION on miss)
//   cfg_wr_en        : write strobe for entry cfg_addr
//   cfg_addr         : entry to write / hit counter to read
//   cfg_key, cfg_action, cfg_entry_valid : entry contents to write
//   stat_rd_en       : request hit counter at cfg_addr
//   stat_rd_data     : hit counter, one cycle after stat_rd_en, else held
// -----------------------------------------------------------------------------
module flow_table_match #(
   parameter int ENTRIES     = 16,
   parameter int ACTION_W    = 8,
   parameter int MISS_ACTION = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       key_valid,
   output logic                       key_ready,
   input  logic [95:0]                flow_key,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic                       res_hit,
   output logic [$clog2(ENTRIES)-1:0] res_index,
   output logic [ACTION_W-1:0]        res_action,
   input  logic                       cfg_wr_en,
   input  logic [$clog2(ENTRIES)-1:0] cfg_addr,
   input  logic [95:0]                cfg_key,
   input  logic [ACTION_W-1:0]        cfg_action,
   input  logic                       cfg_entry_valid,
   input  logic                       stat_rd_en,
   output logic [31:0]                stat_rd_data
);

   localparam int                  IDX_W    = $clog2(ENTRIES);
   localparam logic [ACTION_W-1:0] MISS_ACT = ACTION_W'(MISS_ACTION);

   // Flow table storage
   logic [ENTRIES-1:0]  valid_q;
   logic [95:0]         key_q    [ENTRIES];
   logic [ACTION_W-1:0] action_q [ENTRIES];
   logic [31:0]         hits_q   [ENTRIES];

   // Pipeline control and data
   logic                adv;
   logic                hit_xfer;
   logic [ENTRIES-1:0]  match_d;
   logic                vld_p1_q;
   logic [ENTRIES-1:0]  match_p1_q;
   logic [ACTION_W-1:0] act_p1_q [ENTRIES];
   logic                hit_d;
   logic [IDX_W-1:0]    idx_d;
   logic [ACTION_W-1:0] act_d;
   logic                vld_p2_q;
   logic                hit_p2_q;
   logic [IDX_W-1:0]    idx_p2_q;
   logic [ACTION_W-1:0] act_p2_q;
   logic [31:0]         stat_q;

   // Saturating increment for the hit counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Index of the lowest set bit. The scan runs downward, so the last
   // assignment comes from the lowest set bit.
   function automatic logic [IDX_W-1:0] first_set(input logic [ENTRIES-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (vec[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   // The whole pipeline stalls only when a result is held without a taker.
   assign adv       = !vld_p2_q || res_ready;
   assign key_ready = adv;
   assign hit_xfer  = vld_p2_q && res_ready && hit_p2_q;

   // Table write port. A new entry becomes visible on the following cycle,
   // so a lookup captured on the same edge still sees the old contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            key_q[i]    <= '0;
            action_q[i] <= '0;
         end
      end else if (cfg_wr_en) begin
         valid_q[cfg_addr]  <= cfg_entry_valid;
         key_q[cfg_addr]    <= cfg_key;
         action_q[cfg_addr] <= cfg_action;
      end
   end

   // Hit counters. A write to an entry restarts its count from 0. That
   // clear overrides an increment that lands on the same entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) hits_q[i] <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (cfg_wr_en && (cfg_addr == IDX_W'(i))) begin
               hits_q[i] <= '0;
            end else if (hit_xfer && (idx_p2_q == IDX_W'(i))) begin
               hits_q[i] <= sat_inc(hits_q[i]);
            end
         end
      end
   end

   // Counter read port. The value sampled is the count before any update
   // on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_q <= '0;
      end else if (stat_rd_en) begin
         stat_q <= hits_q[cfg_addr];
      end
   end

   always_comb begin
      match_d = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         match_d[i] = valid_q[i] && (key_q[i] == flow_key);
      end
   end

   // ---- Stage p1: match vector and action snapshot ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
      end else if (adv) begin
         vld_p1_q <= key_valid;
      end
   end

   // The actions are captured together with the match vector, so the result
   // reflects the table contents at acceptance even if an entry is
   // rewritten while the lookup is in flight.
   always_ff @(posedge clk) begin
      if (adv) begin
         match_p1_q <= match_d;
         for (int i = 0; i < ENTRIES; i++) act_p1_q[i] <= action_q[i];
      end
   end

   always_comb begin
      hit_d = |match_p1_q;
      idx_d = first_set(match_p1_q);
      act_d = act_p1_q[idx_d];
      if (!vld_p1_q || !hit_d) begin
         hit_d = 1'b0;
         idx_d = '0;
         act_d = MISS_ACT;
      end
   end

   // ---- Stage p2: encoded result register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2_q <= 1'b0;
         hit_p2_q <= 1'b0;
         idx_p2_q <= '0;
         act_p2_q <= MISS_ACT;
      end else if (adv) begin
         vld_p2_q <= vld_p1_q;
         hit_p2_q <= hit_d;
         idx_p2_q <= idx_d;
         act_p2_q <= act_d;
      end
   end

   assign res_valid    = vld_p2_q;
   assign res_hit      = hit_p2_q;
   assign res_index    = idx_p2_q;
   assign res_action   = act_p2_q;
   assign stat_rd_data = stat_q;

endmodule

// File: tb/tb_flow_table_match.sv
module tb_flow_table_match;

   localparam int          ENTRIES  = 16;
   localparam int          ACTION_W = 8;
   localparam int          IDX_W    = 4;
   localparam int          MISS_I   = 'hA5;
   localparam logic [7:0]  MISS     = 8'hA5;

   localparam logic [95:0] K1 = 96'hC0A8_0001_C0A8_0002_1F90_0050;
   localparam logic [95:0] K2 = 96'h0A00_0001_0A00_0002_0035_0035;
   localparam logic [95:0] K3 = 96'hAC10_0005_AC10_0006_2710_01BB;
   localparam logic [95:0] K4 = 96'hC0A8_0101_0808_0808_C350_0035;
   localparam logic [95:0] K5 = 96'h0A01_0203_0A04_0506_1234_5678;
   localparam logic [95:0] K6 = 96'h0A01_0203_0A04_0506_1234_5679;

   logic             clk;
   logic             rst;
   logic             key_valid;
   logic             key_ready;
   logic [95:0]      flow_key;
   logic             res_valid;
   logic             res_ready;
   logic             res_hit;
   logic [IDX_W-1:0] res_index;
   logic [7:0]       res_action;
   logic             cfg_wr_en;
   logic [IDX_W-1:0] cfg_addr;
   logic [95:0]      cfg_key;
   logic [7:0]       cfg_action;
   logic             cfg_entry_valid;
   logic             stat_rd_en;
   logic [31:0]      stat_rd_data;

   int n_checks;
   int n_fail;

   typedef struct packed {
      logic             hit;
      logic [IDX_W-1:0] idx;
      logic [7:0]       act;
   } res_t;

   // Reference model: table contents, counters, expected results in order.
   logic [ENTRIES-1:0] m_valid;
   logic [95:0]        m_key  [ENTRIES];
   logic [7:0]         m_act  [ENTRIES];
   logic [31:0]        m_hits [ENTRIES];
   res_t               exp_q  [$];

   flow_table_match #(
      .ENTRIES     (ENTRIES),
      .ACTION_W    (ACTION_W),
      .MISS_ACTION (MISS_I)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .key_valid       (key_valid),
      .key_ready       (key_ready),
      .flow_key        (flow_key),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_hit         (res_hit),
      .res_index       (res_index),
      .res_action      (res_action),
      .cfg_wr_en       (cfg_wr_en),
      .cfg_addr        (cfg_addr),
      .cfg_key         (cfg_key),
      .cfg_action      (cfg_action),
      .cfg_entry_valid (cfg_entry_valid),
      .stat_rd_en      (stat_rd_en),
      .stat_rd_data    (stat_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic res_t model_lookup(input logic [95:0] k);
      res_t r;
      r.hit = 1'b0;
      r.idx = '0;
      r.act = MISS;
      for (int i = 0; i < ENTRIES; i++) begin
         if (m_valid[i] && m_key[i] == k) begin
            r.hit = 1'b1;
            r.idx = 4'(i);
            r.act = m_act[i];
            break;
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      m_valid = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         m_key[i]  = '0;
         m_act[i]  = '0;
         m_hits[i] = '0;
      end
      exp_q.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic cfg_write(input int a, input logic [95:0] k, input logic [7:0] act,
                            input logic v);
      cfg_wr_en       = 1'b1;
      cfg_addr        = 4'(a);
      cfg_key         = k;
      cfg_action      = act;
      cfg_entry_valid = v;
      tick();
      cfg_wr_en       = 1'b0;
      m_valid[a] = v;
      m_key[a]   = k;
      m_act[a]   = act;
      m_hits[a]  = '0;
   endtask

   task automatic stat_read(input int a, output logic [31:0] d);
      stat_rd_en = 1'b1;
      cfg_addr   = 4'(a);
      tick();
      stat_rd_en = 1'b0;
      d = stat_rd_data;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick(); tick();
      settle();
      n_checks++;
      if ({res_valid, res_hit, res_index, res_action, stat_rd_data} !== {1'b0, 1'b0, 4'd0, MISS, 32'd0}) begin
         n_fail++;
         $display("FAIL reset_during: got v=%0b h=%0b i=%0d a=%h s=%h expected 0 0 0 %h 0",
                  res_valid, res_hit, res_index, res_action, stat_rd_data, MISS);
      end
      rst = 1'b0;
      tick();
      settle();
      n_checks++;
      if ({res_valid, res_hit, res_index, res_action, stat_rd_data, key_ready} !==
          {1'b0, 1'b0, 4'd0, MISS, 32'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_after: got v=%0b h=%0b i=%0d a=%h s=%h kr=%0b expected 0 0 0 %h 0 1",
                  res_valid, res_hit, res_index, res_action, stat_rd_data, key_ready, MISS);
      end
   endtask

   task automatic test_hit();
      logic [31:0] d;
      cfg_write(3, K1, 8'h5A, 1'b1);
      res_ready = 1'b1;
      key_valid = 1'b1;
      flow_key  = K1;
      tick();
      key_valid = 1'b0;
      settle();
      n_checks++;
      if (res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hit_latency_early: res_valid got %0b expected 0", res_valid);
      end
      tick();
      settle();
      n_checks++;
      if ({res_valid, res_hit, res_index, res_action} !== {1'b1, 1'b1, 4'd3, 8'h5A}) begin
         n_fail++;
         $display("FAIL hit_result: got v=%0b h=%0b i=%0d a=%h expected 1 1 3 5a",
                  res_valid, res_hit, res_index, res_action);
      end
      tick();
      stat_read(3, d);
      n_checks++;
      if (d !== 32'd1) begin
         n_fail++;
         $display("FAIL hit_counter: got %0d expected 1", d);
      end
   endtask

   task automatic test_miss();
      logic [31:0] d;
      key_valid = 1'b1;
      flow_key  = K2;
      tick();
      key_valid = 1'b0;
      tick();
      settle();
      n_checks++;
      if ({res_valid, res_hit, res_index, res_action} !== {1'b1, 1'b0, 4'd0, MISS}) begin
         n_fail++;
         $display("FAIL miss_result: got v=%0b h=%0b i=%0d a=%h expected 1 0 0 %h",
                  res_valid, res_hit, res_index, res_action, MISS);
      end
      tick();
      stat_read(3, d);
      n_checks++;
      if (d !== 32'd1) begin
         n_fail++;
         $display("FAIL miss_counter3: got %0d expected 1", d);
      end
      stat_read(0, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL miss_counter0: got %0d expected 0", d);
      end
   endtask

   task automatic test_priority();
      cfg_write(2, K1, 8'h22, 1'b1);
      cfg_write(7, K1, 8'h77, 1'b1);
      res_ready = 1'b1;
      key_valid = 1'b1;
      flow_key  = K1;
      tick();
      key_valid = 1'b0;
      tick();
      settle();
      n_checks++;
      if ({res_valid, res_hit, res_index, res_action} !== {1'b1, 1'b1, 4'd2, 8'h22}) begin
         n_fail++;
         $display("FAIL priority_lowest: got v=%0b h=%0b i=%0d a=%h expected 1 1 2 22",
                  res_valid, res_hit, res_index, res_action);
      end
      tick();
   endtask

   task automatic test_back_to_back_stall();
      logic [95:0]      keys    [3];
      logic [IDX_W-1:0] exp_idx [3];
      logic [7:0]       exp_act [3];
      logic [12:0]      held;
      bit               have_held;
      int               sent, got, stalls;
      cfg_write(5, K3, 8'h55, 1'b1);
      cfg_write(9, K4, 8'h99, 1'b1);
      keys[0] = K1; exp_idx[0] = 4'd2; exp_act[0] = 8'h22;
      keys[1] = K3; exp_idx[1] = 4'd5; exp_act[1] = 8'h55;
      keys[2] = K4; exp_idx[2] = 4'd9; exp_act[2] = 8'h99;
      sent = 0; got = 0; stalls = 0; have_held = 0; held = '0;
      for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
         res_ready = (cyc >= 5);
         key_valid = (sent < 3);
         if (sent < 3) flow_key = keys[sent];
         settle();
         n_checks++;
         if (key_ready !== (!res_valid || res_ready)) begin
            n_fail++;
            $display("FAIL stall_key_ready: cycle %0d got %0b expected %0b",
                     cyc, key_ready, (!res_valid || res_ready));
         end
         if (res_valid && !res_ready) begin
            stalls++;
            if (have_held) begin
               n_checks++;
               if ({res_hit, res_index, res_action} !== held) begin
                  n_fail++;
                  $display("FAIL stall_hold: got %h expected %h", {res_hit, res_index, res_action}, held);
               end
            end
            held      = {res_hit, res_index, res_action};
            have_held = 1;
         end
         if (res_valid && res_ready) begin
            n_checks++;
            if ({res_hit, res_index, res_action} !== {1'b1, exp_idx[got], exp_act[got]}) begin
               n_fail++;
               $display("FAIL stall_order: result %0d got h=%0b i=%0d a=%h expected 1 %0d %h",
                        got, res_hit, res_index, res_action, exp_idx[got], exp_act[got]);
            end
            got++;
         end
         if (key_valid && key_ready) sent++;
         tick();
      end
      key_valid = 1'b0;
      n_checks++;
      if (got !== 3) begin
         n_fail++;
         $display("FAIL stall_count: got %0d results expected 3", got);
      end
      n_checks++;
      if (stalls !== 3) begin
         n_fail++;
         $display("FAIL stall_cycles: got %0d held cycles expected 3", stalls);
      end
      settle();
      n_checks++;
      if (res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_duplicate: res_valid got %0b expected 0", res_valid);
      end
   endtask

   task automatic test_write_collision();
      logic [31:0] d;
      cfg_write(3, K5, 8'h33, 1'b1);
      res_ready = 1'b0;
      key_valid = 1'b1;
      flow_key  = K5;
      tick();
      key_valid = 1'b0;
      tick();
      settle();
      n_checks++;
      if ({res_valid, res_hit, res_index, res_action} !== {1'b1, 1'b1, 4'd3, 8'h33}) begin
         n_fail++;
         $display("FAIL collide_first: got v=%0b h=%0b i=%0d a=%h expected 1 1 3 33",
                  res_valid, res_hit, res_index, res_action);
      end
      // Same cycle: hit transfer on entry 3, rewrite of entry 3, new lookup.
      res_ready       = 1'b1;
      key_valid       = 1'b1;
      flow_key        = K5;
      cfg_wr_en       = 1'b1;
      cfg_addr        = 4'd3;
      cfg_key         = K6;
      cfg_action      = 8'h3C;
      cfg_entry_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      cfg_wr_en = 1'b0;
      res_ready = 1'b0;
      tick();
      settle();
      n_checks++;
      if ({res_valid, res_hit, res_index, res_action} !== {1'b1, 1'b1, 4'd3, 8'h33}) begin
         n_fail++;
         $display("FAIL collide_old_contents: got v=%0b h=%0b i=%0d a=%h expected 1 1 3 33",
                  res_valid, res_hit, res_index, res_action);
      end
      stat_read(3, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL collide_clear: counter got %0d expected 0", d);
      end
      res_ready = 1'b1;
      tick();
      key_valid = 1'b1;
      flow_key  = K5;
      tick();
      key_valid = 1'b0;
      tick();
      settle();
      n_checks++;
      if ({res_valid, res_hit, res_index, res_action} !== {1'b1, 1'b0, 4'd0, MISS}) begin
         n_fail++;
         $display("FAIL collide_new_contents: got v=%0b h=%0b i=%0d a=%h expected 1 0 0 %h",
                  res_valid, res_hit, res_index, res_action, MISS);
      end
      tick();
   endtask

   task automatic test_reset_midflight();
      logic [95:0] ks [6];
      logic [31:0] d;
      ks[0] = K1; ks[1] = K2; ks[2] = K3; ks[3] = K4; ks[4] = K5; ks[5] = K6;
      res_ready = 1'b1;
      key_valid = 1'b1;
      flow_key  = K6;
      tick();
      flow_key  = K1;
      tick();
      key_valid = 1'b0;
      rst       = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 6; c++) begin
         settle();
         n_checks++;
         if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_no_result: cycle %0d res_valid got %0b expected 0", c, res_valid);
         end
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         key_valid = 1'b1;
         flow_key  = ks[k];
         tick();
         key_valid = 1'b0;
         tick();
         settle();
         n_checks++;
         if ({res_valid, res_hit, res_index, res_action} !== {1'b1, 1'b0, 4'd0, MISS}) begin
            n_fail++;
            $display("FAIL midflight_miss: key %0d got v=%0b h=%0b i=%0d a=%h expected 1 0 0 %h",
                     k, res_valid, res_hit, res_index, res_action, MISS);
         end
         tick();
      end
      stat_read(2, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL midflight_counter: got %0d expected 0", d);
      end
   endtask

   task automatic test_random();
      logic [95:0] pool [6];
      logic [31:0] d;
      res_t        e;
      int          a;
      for (int i = 0; i < 6; i++) pool[i] = {$urandom, $urandom, $urandom};
      for (int i = 0; i < 10; i++) begin
         cfg_write(int'($urandom_range(0, 15)), pool[$urandom_range(0, 5)], 8'($urandom), 1'b1);
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         key_valid       = ($urandom_range(0, 3) != 0);
         flow_key        = ($urandom_range(0, 4) == 0) ? {$urandom, $urandom, $urandom}
                                                       : pool[$urandom_range(0, 5)];
         res_ready       = ($urandom_range(0, 3) != 0);
         cfg_wr_en       = ($urandom_range(0, 9) == 0);
         cfg_addr        = 4'($urandom_range(0, 15));
         cfg_key         = pool[$urandom_range(0, 5)];
         cfg_action      = 8'($urandom);
         cfg_entry_valid = ($urandom_range(0, 4) != 0);
         settle();
         n_checks++;
         if (key_ready !== (!res_valid || res_ready)) begin
            n_fail++;
            $display("FAIL random_key_ready: cycle %0d got %0b expected %0b",
                     cyc, key_ready, (!res_valid || res_ready));
         end
         if (res_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL random_spurious: cycle %0d res_valid got 1 expected 0", cyc);
            end else if (res_ready) begin
               e = exp_q.pop_front();
               if ({res_hit, res_index, res_action} !== e) begin
                  n_fail++;
                  $display("FAIL random_result: cycle %0d got h=%0b i=%0d a=%h expected %0b %0d %h",
                           cyc, res_hit, res_index, res_action, e.hit, e.idx, e.act);
               end
               if (e.hit && !(cfg_wr_en && cfg_addr == e.idx) && m_hits[e.idx] != 32'hFFFF_FFFF)
                  m_hits[e.idx] = m_hits[e.idx] + 1;
            end
         end
         if (key_valid && key_ready) exp_q.push_back(model_lookup(flow_key));
         if (cfg_wr_en) begin
            a = int'(cfg_addr);
            m_valid[a] = cfg_entry_valid;
            m_key[a]   = cfg_key;
            m_act[a]   = cfg_action;
            m_hits[a]  = '0;
         end
         tick();
      end
      cfg_wr_en = 1'b0;
      key_valid = 1'b0;
      res_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         settle();
         if (res_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL random_drain_spurious: res_valid got 1 expected 0");
            end else begin
               e = exp_q.pop_front();
               if ({res_hit, res_index, res_action} !== e) begin
                  n_fail++;
                  $display("FAIL random_drain_result: got h=%0b i=%0d a=%h expected %0b %0d %h",
                           res_hit, res_index, res_action, e.hit, e.idx, e.act);
               end
               if (e.hit && m_hits[e.idx] != 32'hFFFF_FFFF) m_hits[e.idx] = m_hits[e.idx] + 1;
            end
         end
         tick();
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL random_lost: got %0d results outstanding expected 0", exp_q.size());
      end
      for (int i = 0; i < ENTRIES; i++) begin
         stat_read(i, d);
         n_checks++;
         if (d !== m_hits[i]) begin
            n_fail++;
            $display("FAIL random_counter: entry %0d got %0d expected %0d", i, d, m_hits[i]);
         end
      end
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      rst             = 1'b1;
      key_valid       = 1'b0;
      flow_key        = '0;
      res_ready       = 1'b0;
      cfg_wr_en       = 1'b0;
      cfg_addr        = '0;
      cfg_key         = '0;
      cfg_action      = '0;
      cfg_entry_valid = 1'b0;
      stat_rd_en      = 1'b0;
      model_reset();

      test_reset();
      test_hit();
      test_miss();
      test_priority();
      test_back_to_back_stall();
      test_write_collision();
      test_reset_midflight();
      test_random();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
